// File: rtl/bsg_stream_seq_checker.sv
// bsg_stream_seq_checker
// Consumer end of a v_i/ready_and_o stream. It applies a selectable
// backpressure pattern and checks each accepted beat against an arithmetic
// sequence. It counts beats and mismatches and keeps the first mismatch
// for post-mortem inspection.
//
// Handshake: a beat transfers ("fires") on a rising clk edge where both
// v_i and ready_and_o are high. The producer may raise or drop v_i at any
// time. ready_and_o comes straight from a flop and never depends on v_i or
// data_i in the same cycle.
module bsg_stream_seq_checker #(
    parameter int unsigned width_p       = 16,
    parameter int unsigned count_width_p = 32,
    parameter logic [width_p-1:0] start_val_p = '0,
    parameter logic [width_p-1:0] incr_p      = width_p'(1),
    parameter logic [15:0]        lfsr_seed_p = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic [1:0]               mode_i,
    input  logic [count_width_p-1:0] target_beats_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_and_o,
    output logic [count_width_p-1:0] beats_o,
    output logic                     err_o,
    output logic [count_width_p-1:0] err_count_o,
    output logic [count_width_p-1:0] err_beat_o,
    output logic [width_p-1:0]       err_exp_o,
    output logic [width_p-1:0]       err_act_o,
    output logic                     done_o,
    output logic [1:0]               state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ALWAYS = 2'd0;
    localparam logic [1:0] MODE_ALT    = 2'd1;
    localparam logic [1:0] MODE_LFSR   = 2'd2;

    state_e                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic [count_width_p-1:0] beats_q, beats_d;
    logic                     err_q, err_d;
    logic [count_width_p-1:0] err_count_q, err_count_d;
    logic [count_width_p-1:0] err_beat_q, err_beat_d;
    logic [width_p-1:0]       err_exp_q, err_exp_d;
    logic [width_p-1:0]       err_act_q, err_act_d;
    logic [width_p-1:0]       expected_q, expected_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic                     alt_q, alt_d;
    logic                     done_q, done_d;

    logic                     fire;
    logic                     mismatch;
    logic [count_width_p-1:0] beats_inc;
    logic                     hit_target;
    logic [15:0]              lfsr_next;

    // Next-state, handshake and sequence-checking logic.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        beats_d     = beats_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        err_beat_d  = err_beat_q;
        err_exp_d   = err_exp_q;
        err_act_d   = err_act_q;
        expected_d  = expected_q;
        lfsr_d      = lfsr_q;
        alt_d       = alt_q;
        done_d      = done_q;

        fire       = v_i & ready_q;
        mismatch   = fire && (data_i != expected_q);
        beats_inc  = beats_q + count_width_p'(1);
        hit_target = fire && (target_beats_i != '0) && (beats_inc == target_beats_i);
        // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
        lfsr_next  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        // The expected value advances on every accepted beat, even a bad
        // one, so a dropped beat shows as a run of mismatches.
        if (fire) begin
            beats_d    = beats_inc;
            expected_d = expected_q + incr_p;
        end

        if (mismatch) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + count_width_p'(1);
            end
            if (!err_q) begin
                err_d      = 1'b1;
                err_beat_d = beats_q;
                err_exp_d  = expected_q;
                err_act_d  = data_i;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_next;
                if (hit_target) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (!en_i) begin
                    state_d = S_IDLE;
                end else begin
                    case (mode_i)
                        MODE_ALWAYS: ready_d = 1'b1;
                        MODE_ALT: begin
                            ready_d = alt_q;
                            alt_d   = ~alt_q;
                        end
                        MODE_LFSR: ready_d = lfsr_next[0];
                        default:   ready_d = 1'b0;
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset wins over any fire.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            beats_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            err_beat_q  <= '0;
            err_exp_q   <= '0;
            err_act_q   <= '0;
            expected_q  <= start_val_p;
            lfsr_q      <= lfsr_seed_p;
            alt_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            beats_q     <= beats_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            err_beat_q  <= err_beat_d;
            err_exp_q   <= err_exp_d;
            err_act_q   <= err_act_d;
            expected_q  <= expected_d;
            lfsr_q      <= lfsr_d;
            alt_q       <= alt_d;
            done_q      <= done_d;
        end
    end

    assign ready_and_o = ready_q;
    assign beats_o     = beats_q;
    assign err_o       = err_q;
    assign err_count_o = err_count_q;
    assign err_beat_o  = err_beat_q;
    assign err_exp_o   = err_exp_q;
    assign err_act_o   = err_act_q;
    assign done_o      = done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_bsg_stream_seq_checker.sv
// Bench for bsg_stream_seq_checker: a per-cycle vector table covers target
// completion, the first-error capture and dropped beats. Hand sequences
// cover alternate backpressure, 4-bit wrap, LFSR backpressure and mid-run
// reset.
module tb_bsg_stream_seq_checker;

  logic        clk = 1'b0;
  logic        rst, en, v, rdy, err, done;
  logic [1:0]  mode, st;
  logic [31:0] tgt, beats, ec, eb;
  logic [15:0] data, ee, ea;

  logic       w_rst, w_en, w_v, w_rdy, w_err, w_done;
  logic [1:0] w_st;
  logic [3:0] w_data, w_ee, w_ea;
  logic [7:0] w_beats, w_ec, w_eb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bsg_stream_seq_checker dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .mode_i(mode),
    .target_beats_i(tgt), .v_i(v), .data_i(data), .ready_and_o(rdy),
    .beats_o(beats), .err_o(err), .err_count_o(ec), .err_beat_o(eb),
    .err_exp_o(ee), .err_act_o(ea), .done_o(done), .state_o(st)
  );

  bsg_stream_seq_checker #(
    .width_p(4), .count_width_p(8), .start_val_p(4'd14), .incr_p(4'd1)
  ) u_w4 (
    .clk_i(clk), .reset_i(w_rst), .en_i(w_en), .mode_i(2'd0),
    .target_beats_i(8'd0), .v_i(w_v), .data_i(w_data), .ready_and_o(w_rdy),
    .beats_o(w_beats), .err_o(w_err), .err_count_o(w_ec), .err_beat_o(w_eb),
    .err_exp_o(w_ee), .err_act_o(w_ea), .done_o(w_done), .state_o(w_st)
  );

  typedef struct {
    logic        rst, en;
    logic [1:0]  mode;
    logic [31:0] tgt;
    logic        v;
    logic [15:0] data;
    logic        x_rdy;
    logic [31:0] x_beats;
    logic        x_err;
    logic [31:0] x_ec, x_eb;
    logic [15:0] x_ee, x_ea;
    logic        x_done;
  } vec_t;

  vec_t vecs[$];
  logic rec_a [1:30];
  logic rec_b [1:30];

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s idx=%0d got=%0h want=%0h", name, idx, got, want);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic [31:0] t,
                     input logic vv, input logic [15:0] d, input logic xr, input logic [31:0] xb,
                     input logic xe, input logic [31:0] xc, input logic [31:0] xeb,
                     input logic [15:0] xee, input logic [15:0] xea, input logic xd);
    vec_t s;
    s.rst = r; s.en = e; s.mode = m; s.tgt = t; s.v = vv; s.data = d;
    s.x_rdy = xr; s.x_beats = xb; s.x_err = xe; s.x_ec = xc; s.x_eb = xeb;
    s.x_ee = xee; s.x_ea = xea; s.x_done = xd;
    vecs.push_back(s);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Enters RUN in mode 2 from IDLE and records ready for 30 RUN cycles.
  task automatic run_lfsr(input bit second);
    logic [15:0] l;
    l = 16'hACE1;
    en = 1'b1; mode = 2'd2; tgt = 32'd0;
    @(posedge clk); #1;
    chk("lfsr_first_ready", 0, {31'd0, rdy}, 32'd0);
    for (int k = 1; k <= 30; k++) begin
      v = 1'($urandom_range(0, 1));
      data = 16'($urandom_range(0, 65535));
      @(posedge clk); #1;
      l = lfsr_step(l);
      chk("lfsr_ready", k, {31'd0, rdy}, {31'd0, l[0]});
      if (second) chk("lfsr_repeat", k, {31'd0, rdy}, {31'd0, rec_a[k]});
      else rec_a[k] = rdy;
      if (second) rec_b[k] = rdy;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, idx;
    logic pre;

    rst = 1'b1; en = 1'b0; mode = 2'd0; tgt = 32'd0; v = 1'b0; data = 16'd0;
    w_rst = 1'b1; w_en = 1'b0; w_v = 1'b0; w_data = 4'd0;

    // Target of 10 beats, always ready.
    add(1,0,0,0,0,0,   0,0,0,0,0,0,0,0);
    add(0,1,0,10,1,0,  0,0,0,0,0,0,0,0);
    add(0,1,0,10,1,0,  1,0,0,0,0,0,0,0);
    for (int i = 0; i < 10; i++)
      add(0,1,0,10,1,16'(i), (i == 9) ? 1'b0 : 1'b1, 32'(i + 1), 0,0,0,0,0, (i == 9) ? 1'b1 : 1'b0);
    add(0,1,0,10,1,10, 0,10,0,0,0,0,0,1);
    add(0,1,0,10,1,10, 0,10,0,0,0,0,0,1);
    // First mismatch at beat 3, then en drops while a beat fires.
    add(1,0,0,0,0,0,   0,0,0,0,0,0,0,0);
    add(0,1,0,0,1,0,   0,0,0,0,0,0,0,0);
    add(0,1,0,0,1,0,   1,0,0,0,0,0,0,0);
    add(0,1,0,0,1,0,   1,1,0,0,0,0,0,0);
    add(0,1,0,0,1,1,   1,2,0,0,0,0,0,0);
    add(0,1,0,0,1,2,   1,3,0,0,0,0,0,0);
    add(0,1,0,0,1,7,   1,4,1,1,3,3,7,0);
    add(0,1,0,0,1,4,   1,5,1,1,3,3,7,0);
    add(0,0,0,0,1,5,   0,6,1,1,3,3,7,0);
    add(0,0,0,0,1,6,   0,6,1,1,3,3,7,0);
    // Beat 2 dropped: three mismatches, capture frozen at the first.
    add(1,0,0,0,0,0,   0,0,0,0,0,0,0,0);
    add(0,1,0,0,1,0,   0,0,0,0,0,0,0,0);
    add(0,1,0,0,1,0,   1,0,0,0,0,0,0,0);
    add(0,1,0,0,1,0,   1,1,0,0,0,0,0,0);
    add(0,1,0,0,1,1,   1,2,0,0,0,0,0,0);
    add(0,1,0,0,1,3,   1,3,1,1,2,2,3,0);
    add(0,1,0,0,1,4,   1,4,1,2,2,2,3,0);
    add(0,1,0,0,1,5,   1,5,1,3,2,2,3,0);
    // Target lowered below beats_o never sets done.
    add(0,1,0,2,1,6,   1,6,1,4,2,2,3,0);
    add(0,1,0,0,0,6,   1,6,1,4,2,2,3,0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      tgt = vecs[i].tgt; v = vecs[i].v; data = vecs[i].data;
      @(posedge clk); #1;
      chk("ready", i, {31'd0, rdy}, {31'd0, vecs[i].x_rdy});
      chk("beats", i, beats, vecs[i].x_beats);
      chk("err", i, {31'd0, err}, {31'd0, vecs[i].x_err});
      chk("err_count", i, ec, vecs[i].x_ec);
      chk("err_beat", i, eb, vecs[i].x_eb);
      chk("err_exp", i, {16'd0, ee}, {16'd0, vecs[i].x_ee});
      chk("err_act", i, {16'd0, ea}, {16'd0, vecs[i].x_ea});
      chk("done", i, {31'd0, done}, {31'd0, vecs[i].x_done});
    end

    // Alternate mode: ready 1,0,1,0 and 8 beats in 16 RUN cycles.
    en = 1'b0; v = 1'b0;
    do_reset();
    en = 1'b1; mode = 2'd1; tgt = 32'd0; v = 1'b1; data = 16'd0;
    @(posedge clk); #1;
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      pre = rdy;
      data = 16'(nb);
      @(posedge clk); #1;
      if (pre) nb++;
      chk("alt_ready", i, {31'd0, rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("alt_beats", 0, beats, 32'd8);
    chk("alt_err", 0, {31'd0, err}, 32'd0);

    // Four-bit sequence wrapping 14,15,0,1.
    w_rst = 1'b1;
    @(posedge clk); #1;
    w_rst = 1'b0; w_en = 1'b1; w_v = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      pre = w_rdy;
      w_data = 4'(14 + idx);
      @(posedge clk); #1;
      if (pre) idx++;
    end
    w_v = 1'b0;
    chk("wrap_timeout", 0, 32'(idx), 32'd4);
    @(posedge clk); #1;
    chk("wrap_beats", 0, {24'd0, w_beats}, 32'd4);
    chk("wrap_err", 0, {31'd0, w_err}, 32'd0);
    chk("wrap_err_count", 0, {24'd0, w_ec}, 32'd0);

    // LFSR backpressure, reset mid-run, then the same ready sequence again.
    en = 1'b0; v = 1'b0;
    do_reset();
    run_lfsr(1'b0);
    rst = 1'b1; v = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; v = 1'b0;
    chk("rst_ready", 0, {31'd0, rdy}, 32'd0);
    chk("rst_beats", 0, beats, 32'd0);
    chk("rst_err", 0, {31'd0, err}, 32'd0);
    chk("rst_err_count", 0, ec, 32'd0);
    chk("rst_err_beat", 0, eb, 32'd0);
    chk("rst_err_exp", 0, {16'd0, ee}, 32'd0);
    chk("rst_err_act", 0, {16'd0, ea}, 32'd0);
    chk("rst_done", 0, {31'd0, done}, 32'd0);
    chk("rst_state", 0, {30'd0, st}, 32'd0);
    run_lfsr(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
